// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory game: shows the sequence, collects answers, ends in win/error/timeout.
// Define MOSTRA_SEQUENCIA_EN to enable the display phase (states 03/04/05).
module unidade_controle_jogo (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       fimL,
   input  logic       fimE,
   input  logic       fimTMR,
   input  logic       jogada_feita,
   input  logic       chavesIgualMemoria,
   input  logic       enderecoIgualLimite,
   input  logic       timeout,
   output logic       zeraR,
   output logic       zeraE,
   output logic       zeraL,
   output logic       zeraM,
   output logic       zeraTMR,
   output logic       registraR,
   output logic       registraM,
   output logic       contaE,
   output logic       contaL,
   output logic       contaTMR,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [4:0] db_estado
);

   localparam logic [4:0] INICIAL        = 5'h00;
   localparam logic [4:0] PREPARACAO     = 5'h01;
   localparam logic [4:0] INICIO_RODADA  = 5'h02;
   localparam logic [4:0] CARREGA_MOSTRA = 5'h03;
   localparam logic [4:0] MOSTRA         = 5'h04;
   localparam logic [4:0] PROXIMO_MOSTRA = 5'h05;
   localparam logic [4:0] ZERA_ENDERECO  = 5'h06;
   localparam logic [4:0] ESPERA_JOGADA  = 5'h07;
   localparam logic [4:0] REGISTRA       = 5'h08;
   localparam logic [4:0] COMPARA        = 5'h09;
   localparam logic [4:0] PROXIMA_JOGADA = 5'h0A;
   localparam logic [4:0] PROXIMA_RODADA = 5'h0B;
   localparam logic [4:0] FIM_TIMEOUT    = 5'h0D;
   localparam logic [4:0] FIM_ACERTO     = 5'h0E;
   localparam logic [4:0] FIM_ERRO       = 5'h0F;

   logic [4:0] estado;
   logic [4:0] proximo;

   // fimE is a debug flag only; fimTMR is unused when the display phase is disabled
   logic unused_inputs;
   assign unused_inputs = fimE ^ fimTMR;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         estado <= INICIAL;
      else
         estado <= proximo;
   end

   always_comb begin
      proximo = INICIAL;
      case (estado)
         INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO:     proximo = INICIO_RODADA;
`ifdef MOSTRA_SEQUENCIA_EN
         INICIO_RODADA:  proximo = CARREGA_MOSTRA;
         CARREGA_MOSTRA: proximo = MOSTRA;
         MOSTRA: begin
            if (!fimTMR)
               proximo = MOSTRA;
            else if (enderecoIgualLimite)
               proximo = ZERA_ENDERECO;
            else
               proximo = PROXIMO_MOSTRA;
         end
         PROXIMO_MOSTRA: proximo = CARREGA_MOSTRA;
`else
         INICIO_RODADA:  proximo = ZERA_ENDERECO;
`endif
         ZERA_ENDERECO:  proximo = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            // a press in the same cycle as the timeout still counts
            if (jogada_feita)
               proximo = REGISTRA;
            else if (timeout)
               proximo = FIM_TIMEOUT;
            else
               proximo = ESPERA_JOGADA;
         end
         REGISTRA:       proximo = COMPARA;
         COMPARA: begin
            if (!chavesIgualMemoria)
               proximo = FIM_ERRO;
            else if (enderecoIgualLimite && fimL)
               proximo = FIM_ACERTO;
            else if (enderecoIgualLimite)
               proximo = PROXIMA_RODADA;
            else
               proximo = PROXIMA_JOGADA;
         end
         PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
         PROXIMA_RODADA: proximo = INICIO_RODADA;
         FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
         FIM_ACERTO:     proximo = iniciar ? PREPARACAO : FIM_ACERTO;
         FIM_ERRO:       proximo = iniciar ? PREPARACAO : FIM_ERRO;
         default:        proximo = INICIAL;
      endcase
   end

   always_comb begin
      zeraR      = 1'b0;
      zeraE      = 1'b0;
      zeraL      = 1'b0;
      zeraM      = 1'b0;
      zeraTMR    = 1'b0;
      registraR  = 1'b0;
      registraM  = 1'b0;
      contaE     = 1'b0;
      contaL     = 1'b0;
      contaTMR   = 1'b0;
      pronto     = 1'b0;
      ganhou     = 1'b0;
      perdeu     = 1'b0;
      db_timeout = 1'b0;
      case (estado)
         PREPARACAO: begin
            zeraE   = 1'b1;
            zeraL   = 1'b1;
            zeraR   = 1'b1;
            zeraM   = 1'b1;
            zeraTMR = 1'b1;
         end
         INICIO_RODADA: begin
            zeraE = 1'b1;
`ifdef MOSTRA_SEQUENCIA_EN
            zeraTMR = 1'b1;
`endif
         end
`ifdef MOSTRA_SEQUENCIA_EN
         CARREGA_MOSTRA: registraM = 1'b1;
         MOSTRA:         contaTMR  = 1'b1;
         PROXIMO_MOSTRA: begin
            contaE  = 1'b1;
            zeraTMR = 1'b1;
         end
`endif
         ZERA_ENDERECO: begin
            zeraE = 1'b1;
            zeraR = 1'b1;
         end
         REGISTRA: begin
            registraR = 1'b1;
            registraM = 1'b1;
         end
         PROXIMA_JOGADA: contaE = 1'b1;
         PROXIMA_RODADA: contaL = 1'b1;
         FIM_TIMEOUT: begin
            pronto     = 1'b1;
            perdeu     = 1'b1;
            db_timeout = 1'b1;
         end
         FIM_ACERTO: begin
            pronto = 1'b1;
            ganhou = 1'b1;
         end
         FIM_ERRO: begin
            pronto = 1'b1;
            perdeu = 1'b1;
         end
         default: ;
      endcase
   end

   // unused codes (and 03/04/05 when the display phase is off) read back as inicial
   always_comb begin
      db_estado = estado;
      case (estado)
         5'h0C, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17,
         5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F: db_estado = INICIAL;
`ifndef MOSTRA_SEQUENCIA_EN
         CARREGA_MOSTRA, MOSTRA, PROXIMO_MOSTRA: db_estado = INICIAL;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo; follows the display phase when MOSTRA_SEQUENCIA_EN is defined.
module tb_unidade_controle_jogo;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       fimL = 1'b0;
   logic       fimE = 1'b0;
   logic       fimTMR = 1'b0;
   logic       jogada_feita = 1'b0;
   logic       chavesIgualMemoria = 1'b0;
   logic       enderecoIgualLimite = 1'b0;
   logic       timeout = 1'b0;
   logic       zeraR, zeraE, zeraL, zeraM, zeraTMR;
   logic       registraR, registraM, contaE, contaL, contaTMR;
   logic       pronto, ganhou, perdeu, db_timeout;
   logic [4:0] db_estado;

   int errors = 0;
   int checks = 0;

   // output vector bit order: zeraR zeraE zeraL zeraM zeraTMR registraR registraM contaE contaL contaTMR pronto ganhou perdeu db_timeout
   localparam logic [13:0] O_NONE  = 14'h0000;
   localparam logic [13:0] O_ZR    = 14'h2000;
   localparam logic [13:0] O_ZE    = 14'h1000;
   localparam logic [13:0] O_ZL    = 14'h0800;
   localparam logic [13:0] O_ZM    = 14'h0400;
   localparam logic [13:0] O_ZTMR  = 14'h0200;
   localparam logic [13:0] O_RR    = 14'h0100;
   localparam logic [13:0] O_RM    = 14'h0080;
   localparam logic [13:0] O_CE    = 14'h0040;
   localparam logic [13:0] O_CL    = 14'h0020;
   localparam logic [13:0] O_CTMR  = 14'h0010;
   localparam logic [13:0] O_PR    = 14'h0008;
   localparam logic [13:0] O_GA    = 14'h0004;
   localparam logic [13:0] O_PE    = 14'h0002;
   localparam logic [13:0] O_DT    = 14'h0001;

   wire [13:0] outs = {zeraR, zeraE, zeraL, zeraM, zeraTMR, registraR, registraM,
                       contaE, contaL, contaTMR, pronto, ganhou, perdeu, db_timeout};

   unidade_controle_jogo dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .fimL(fimL), .fimE(fimE),
      .fimTMR(fimTMR), .jogada_feita(jogada_feita),
      .chavesIgualMemoria(chavesIgualMemoria), .enderecoIgualLimite(enderecoIgualLimite),
      .timeout(timeout), .zeraR(zeraR), .zeraE(zeraE), .zeraL(zeraL), .zeraM(zeraM),
      .zeraTMR(zeraTMR), .registraR(registraR), .registraM(registraM), .contaE(contaE),
      .contaL(contaL), .contaTMR(contaTMR), .pronto(pronto), .ganhou(ganhou),
      .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [4:0] st, input logic [13:0] o);
      checks++;
      assert ({db_estado, outs} === {st, o}) else begin
         errors++;
         $error("FAIL %s: observed estado=%02h outs=%04h expected estado=%02h outs=%04h",
                tag, db_estado, outs, st, o);
      end
      $display("step %-14s estado=%02h outs=%04h", tag, db_estado, outs);
   endtask

   task automatic step(input string tag, input logic [4:0] st, input logic [13:0] o);
      @(negedge clock);
      chk(tag, st, o);
   endtask

   // from inicio_rodada (already checked) on to espera_jogada; shows a single item (limit reached)
   task automatic round_to_wait();
`ifdef MOSTRA_SEQUENCIA_EN
      step("carrega", 5'h03, O_RM);
      step("mostra", 5'h04, O_CTMR);
      step("mostra_hold", 5'h04, O_CTMR);
      fimTMR = 1'b1;
      enderecoIgualLimite = 1'b1;
      step("zera_end", 5'h06, O_ZE | O_ZR);
      fimTMR = 1'b0;
`else
      step("zera_end", 5'h06, O_ZE | O_ZR);
`endif
      step("espera", 5'h07, O_NONE);
   endtask

   logic [13:0] o_rodada;

   initial begin
`ifdef MOSTRA_SEQUENCIA_EN
      o_rodada = O_ZE | O_ZTMR;
`else
      o_rodada = O_ZE;
`endif
      @(negedge clock);
      @(negedge clock);
      chk("reset", 5'h00, O_NONE);
      reset = 1'b0;
      step("idle", 5'h00, O_NONE);

      iniciar = 1'b1;
      step("prep", 5'h01, O_ZR | O_ZE | O_ZL | O_ZM | O_ZTMR);
      iniciar = 1'b0;
      step("rodada0", 5'h02, o_rodada);
      round_to_wait();
      step("espera_hold", 5'h07, O_NONE);
      iniciar = 1'b1;
      step("ign_iniciar", 5'h07, O_NONE);
      iniciar = 1'b0;

      // round 0 answered correctly, not the last round
      jogada_feita = 1'b1;
      chavesIgualMemoria = 1'b1;
      enderecoIgualLimite = 1'b1;
      fimL = 1'b0;
      step("registra", 5'h08, O_RR | O_RM);
      jogada_feita = 1'b0;
      step("compara", 5'h09, O_NONE);
      step("prox_rodada", 5'h0B, O_CL);
      step("rodada1", 5'h02, o_rodada);
      round_to_wait();

      // mid-round match
      jogada_feita = 1'b1;
      enderecoIgualLimite = 1'b0;
      step("registra2", 5'h08, O_RR | O_RM);
      jogada_feita = 1'b0;
      step("compara2", 5'h09, O_NONE);
      step("prox_jogada", 5'h0A, O_CE);
      step("espera2", 5'h07, O_NONE);

      // press and timeout together: press wins, then mismatch
      jogada_feita = 1'b1;
      timeout = 1'b1;
      step("press_vs_tmo", 5'h08, O_RR | O_RM);
      jogada_feita = 1'b0;
      timeout = 1'b0;
      chavesIgualMemoria = 1'b0;
      step("compara3", 5'h09, O_NONE);
      step("fim_erro", 5'h0F, O_PR | O_PE);
      for (int i = 0; i < 20; i++) begin
         jogada_feita = i[0];
         timeout = i[1];
         step("erro_hold", 5'h0F, O_PR | O_PE);
      end
      jogada_feita = 1'b0;
      timeout = 1'b0;
      iniciar = 1'b1;
      step("restart1", 5'h01, O_ZR | O_ZE | O_ZL | O_ZM | O_ZTMR);
      iniciar = 1'b0;
      step("rodada2", 5'h02, o_rodada);
      round_to_wait();

      timeout = 1'b1;
      step("fim_timeout", 5'h0D, O_PR | O_PE | O_DT);
      timeout = 1'b0;
      step("tmo_hold", 5'h0D, O_PR | O_PE | O_DT);
      iniciar = 1'b1;
      step("restart2", 5'h01, O_ZR | O_ZE | O_ZL | O_ZM | O_ZTMR);
      iniciar = 1'b0;
      step("rodada3", 5'h02, o_rodada);
      round_to_wait();

      // last round, correct answer
      jogada_feita = 1'b1;
      chavesIgualMemoria = 1'b1;
      enderecoIgualLimite = 1'b1;
      fimL = 1'b1;
      step("registra4", 5'h08, O_RR | O_RM);
      jogada_feita = 1'b0;
      step("compara4", 5'h09, O_NONE);
      step("fim_acerto", 5'h0E, O_PR | O_GA);
      step("acerto_hold", 5'h0E, O_PR | O_GA);

      // asynchronous reset in the middle of a round
      iniciar = 1'b1;
      step("restart3", 5'h01, O_ZR | O_ZE | O_ZL | O_ZM | O_ZTMR);
      iniciar = 1'b0;
      fimL = 1'b0;
      enderecoIgualLimite = 1'b0;
      step("rodada4", 5'h02, o_rodada);
`ifdef MOSTRA_SEQUENCIA_EN
      step("carrega5", 5'h03, O_RM);
      step("mostra5", 5'h04, O_CTMR);
`else
      step("zera_end5", 5'h06, O_ZE | O_ZR);
`endif
      reset = 1'b1;
      #1;
      chk("async_reset", 5'h00, O_NONE);
      @(negedge clock);
      reset = 1'b0;
      step("post_reset", 5'h00, O_NONE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
